// File: rtl/s2mm_sched_pkg.sv
// Shared definitions for the s2mm frame-buffer scheduler.
//   sched_state_t : run/stop sequencer state encoding
//   STOP_MIN_CYC  : minimum STOP dwell, covers the lag before the writer's
//                   resetting flag reflects the soft reset
//   BUF_NUM_MIN/MAX : legal range of the buffer ring size
package s2mm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sched_state_t;

  localparam int STOP_MIN_CYC = 2;
  localparam int BUF_NUM_MIN  = 3;
  localparam int BUF_NUM_MAX  = 4;

endpackage

// File: rtl/s2mm_buf_pick.sv
// Next-writer buffer chooser (combinational).
//   cur : buffer the writer is (about to be) filling
//   rd  : buffer the reader is (about to be) scanning
//   w   : first index (cur+k) mod C_BUF_NUM, k = 1..C_BUF_NUM-1, not equal to rd
// With at least three buffers a candidate always exists.
module s2mm_buf_pick #(
  parameter int C_BUF_NUM  = 3,
  parameter int C_IDX_BITS = 2
) (
  input  logic [C_IDX_BITS-1:0] cur,
  input  logic [C_IDX_BITS-1:0] rd,
  output logic [C_IDX_BITS-1:0] w
);

  logic [C_IDX_BITS-1:0] cand;
  logic                  found;

  always_comb begin
    w     = '0;
    found = 1'b0;
    cand  = cur;
    for (int k = 1; k < C_BUF_NUM; k++) begin
      // wrap by compare so non-power-of-2 rings work
      cand = (cand == C_IDX_BITS'(C_BUF_NUM - 1)) ? '0 : cand + 1'b1;
      if (!found && (cand != rd)) begin
        w     = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s2mm_buf_sched.sv
// Frame-buffer scheduler and run/stop sequencer for the s2mm writer and
// its companion mm2s reader.
// Ports:
//   clk, resetn          : clock, async active-low reset
//   enable               : run request
//   buf_addr             : packed buffer base addresses, buffer i at [i*AW +: AW]
//   s2mm_soft_resetn     : writer soft reset (high while running)
//   s2mm_resetting       : writer still draining a transaction
//   s2mm_sof, s2mm_addr  : writer frame pulse / next writer base address
//   mm2s_sof, mm2s_addr  : reader frame pulse / reader base address
//   mm2s_valid           : reader buffer holds a complete frame
//   busy                 : sequencer not idle
//   wr_idx, rd_idx       : buffer indices behind s2mm_addr / mm2s_addr
// Optional (macro S2MM_BUF_SCHED_STAT_EN): wr_frames, rd_frames, rd_repeats.
//
// state | meaning
// IDLE  | writer held in soft reset, writer sofs ignored
// RUN   | writer released, buffers rotate on each writer sof
// STOP  | writer back in reset, wait >= STOP_MIN_CYC and resetting low
module s2mm_buf_sched
  import s2mm_sched_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_BUF_NUM    = 3,
  parameter int C_IDX_BITS   = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              enable,
  input  logic [C_BUF_NUM*C_ADDR_WIDTH-1:0] buf_addr,
  output logic                              s2mm_soft_resetn,
  input  logic                              s2mm_resetting,
  input  logic                              s2mm_sof,
  output logic [C_ADDR_WIDTH-1:0]           s2mm_addr,
  input  logic                              mm2s_sof,
  output logic [C_ADDR_WIDTH-1:0]           mm2s_addr,
  output logic                              mm2s_valid,
  output logic                              busy,
  output logic [C_IDX_BITS-1:0]             wr_idx,
  output logic [C_IDX_BITS-1:0]             rd_idx
`ifdef S2MM_BUF_SCHED_STAT_EN
  ,
  output logic [31:0]                       wr_frames,
  output logic [31:0]                       rd_frames,
  output logic [31:0]                       rd_repeats
`endif
);

  if (C_BUF_NUM < BUF_NUM_MIN || C_BUF_NUM > BUF_NUM_MAX ||
      (1 << C_IDX_BITS) < C_BUF_NUM) begin : g_bad_cfg
    $error("s2mm_buf_sched: illegal C_BUF_NUM / C_IDX_BITS");
  end

  sched_state_t state, state_next;
  logic [1:0]   stop_cnt;
  logic         stop_done;

  logic [C_IDX_BITS-1:0] cur, lat, rd, w;
  logic [C_IDX_BITS-1:0] cur_next, rd_next, w_pick;
  logic                  cur_vld, lat_vld;
  logic                  honoured, lat_upd, rd_take, to_idle;

  assign stop_done = (stop_cnt == 2'd0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !s2mm_resetting) state_next = RUN;
      RUN:     if (!enable) state_next = STOP;
      STOP:    if (stop_done && !s2mm_resetting) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      s2mm_soft_resetn <= 1'b0;
      stop_cnt         <= '0;
    end else begin
      state            <= state_next;
      s2mm_soft_resetn <= (state_next == RUN);
      if (state == RUN && state_next == STOP)
        stop_cnt <= 2'(STOP_MIN_CYC - 1);
      else if (state == STOP && !stop_done)
        stop_cnt <= stop_cnt - 2'd1;
    end
  end

  assign busy     = (state != IDLE);
  assign honoured = s2mm_sof && (state == RUN);
  assign lat_upd  = honoured && cur_vld;
  // reader always takes the pre-update lat, even with a coincident writer sof
  assign rd_take  = mm2s_sof && lat_vld;
  assign to_idle  = (state == STOP) && (state_next == IDLE);
  assign cur_next = honoured ? w : cur;
  assign rd_next  = rd_take ? lat : rd;

  s2mm_buf_pick #(
    .C_BUF_NUM  (C_BUF_NUM),
    .C_IDX_BITS (C_IDX_BITS)
  ) u_pick (
    .cur (cur_next),
    .rd  (rd_next),
    .w   (w_pick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur        <= '0;
      cur_vld    <= 1'b0;
      lat        <= '0;
      lat_vld    <= 1'b0;
      rd         <= '0;
      mm2s_valid <= 1'b0;
      w          <= C_IDX_BITS'(1);
    end else begin
      cur <= cur_next;
      rd  <= rd_next;
      w   <= w_pick;
      if (lat_upd) lat <= cur;
      if (rd_take) mm2s_valid <= 1'b1;
      // rd / mm2s_valid survive the stop: the reader may still be scanning rd
      if (to_idle) begin
        cur_vld <= 1'b0;
        lat_vld <= 1'b0;
      end else begin
        if (honoured) cur_vld <= 1'b1;
        if (lat_upd)  lat_vld <= 1'b1;
      end
    end
  end

  assign wr_idx = w;
  assign rd_idx = rd;

  always_comb begin
    s2mm_addr = buf_addr[C_ADDR_WIDTH-1:0];
    mm2s_addr = buf_addr[C_ADDR_WIDTH-1:0];
    for (int i = 0; i < C_BUF_NUM; i++) begin
      if (w == C_IDX_BITS'(i))  s2mm_addr = buf_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
      if (rd == C_IDX_BITS'(i)) mm2s_addr = buf_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
    end
  end

`ifdef S2MM_BUF_SCHED_STAT_EN
  // lat_new: lat has moved since the last reader sof
  logic lat_new;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_frames  <= '0;
      rd_frames  <= '0;
      rd_repeats <= '0;
      lat_new    <= 1'b0;
    end else begin
      if (honoured) wr_frames <= wr_frames + 32'd1;
      if (mm2s_sof) begin
        rd_frames <= rd_frames + 32'd1;
        if (!lat_vld || !lat_new) rd_repeats <= rd_repeats + 32'd1;
      end
      if (to_idle)       lat_new <= 1'b0;
      else if (lat_upd)  lat_new <= 1'b1;
      else if (mm2s_sof) lat_new <= 1'b0;
    end
  end
`endif

endmodule
